altpll_pll: RTL and testbench
=============================

Name: altpll_pll

Overview:
- Digital clock-generation core behind the memory-mapped PLL wrapper.
- Takes the board reference clock and produces four divided, phase-offset clock outputs c0..c3, plus a lock indication.
- Everything is synchronous to the rising edge of inclk0: one counter per output and one lock counter.
- Outputs stay low until a programmable lock delay has elapsed after reset release.

Parameters:
- LOCK_CYCLES, 64: inclk0 rising edges after reset deassertion before locked asserts; legal 1..65535.
- C0_DIV, 2: c0 period in inclk0 cycles; legal 2..256.
- C0_HIGH, 1: c0 high time in inclk0 cycles; legal 1..C0_DIV-1.
- C0_PHASE, 0: c0 counter start value at lock, i.e. the phase offset in inclk0 cycles; legal 0..C0_DIV-1.
- C1_DIV, 4 / C1_HIGH, 2 / C1_PHASE, 0: same meaning for c1.
- C2_DIV, 4 / C2_HIGH, 2 / C2_PHASE, 2: same meaning for c2 (default is c1 inverted).
- C3_DIV, 8 / C3_HIGH, 4 / C3_PHASE, 0: same meaning for c3.

Ports:
- inclk0, input, 1: reference clock; the only clock in the block.
- areset_n, input, 1: asynchronous, active-low reset.
- clkena, input, 4: per-output enable; bit k gates ck; synchronous.
- c0, output, 1: divided clock 0.
- c1, output, 1: divided clock 1.
- c2, output, 1: divided clock 2.
- c3, output, 1: divided clock 3.
- locked, output, 1: high once the lock delay has elapsed.

Behaviour:
- Reset (areset_n=0), immediate and asynchronous:
  - locked=0, c0..c3=0.
  - Lock counter=0; all divider counters=0.
- Lock counter:
  - After reset release it increments on each inclk0 rising edge while locked=0.
  - On the edge where it equals LOCK_CYCLES-1, locked becomes 1, so locked rises on the LOCK_CYCLES-th edge after release.
  - locked then stays 1 until the next reset; the counter stops.
- Lock edge: on the same edge that locked goes 1, each divider counter cnt_k loads Ck_PHASE and ck stays 0.
- Each edge while locked=1, for each k:
  - ck <= clkena[k] & (cnt_k < Ck_HIGH).
  - cnt_k <= (cnt_k == Ck_DIV-1) ? 0 : cnt_k+1.
- Output latency: each ck is a registered output, one edge after the counter value that selects it.
- Waveform in steady state, with clkena[k]=1:
  - ck has period Ck_DIV inclk0 cycles and is high for Ck_HIGH consecutive cycles.
  - The first high cycle after lock starts Ck_PHASE-dependent: if Ck_PHASE<Ck_HIGH, ck is high on the first edge after lock.
- clkena:
  - clkena[k]=0 forces ck low on the next edge.
  - cnt_k keeps running, so re-enabling restores the original phase relationship with no glitch or shortened pulse.
- While locked=0, clkena has no effect and all outputs stay 0.
- Counter widths: 8 bits for the divider counters, 16 bits for the lock counter. Wrap-around occurs only at Ck_DIV-1.
- Reset asserted mid-operation:
  - All outputs drop to 0 asynchronously.
  - After release the full lock sequence repeats from 0.
- Parameter checks: out-of-range parameter values cause an elaboration-time error (generate-time check). No runtime checking.
- Outputs are never combinationally derived from inclk0; no clock gating.

Test Plan:
1. Release areset_n with default parameters and clkena=4'hF, then count edges → locked=0 through edge 63 and locked=1 on edge 64; c0..c3 stay 0 through the lock edge.
2. Continue 32 edges after lock → c0 toggles every edge (pattern 1,0,1,0…); c1 pattern 1,1,0,0 repeating; c2 pattern 0,0,1,1 (exact complement of c1); c3 pattern 1,1,1,1,0,0,0,0.
3. Set C3_DIV=5, C3_HIGH=2, C3_PHASE=3 with LOCK_CYCLES=4 → locked rises on edge 4; c3 from edge 5 reads 0,0,1,1,0,0,0,1,1,0…
4. Hold clkena[1]=0 for 6 edges mid-stream, then set it to 1 → c1=0 one edge after deassertion; after re-enable, c1 resumes in its original 1,1,0,0 phase alignment relative to c3.
5. Assert areset_n=0 asynchronously between edges while locked → locked and all ck go 0 immediately; after release, locked re-asserts exactly LOCK_CYCLES edges later.
6. Set LOCK_CYCLES=1 → locked=1 on the first edge after release; outputs begin on the second edge.

Source files
------------

// File: rtl/altpll_pll_if.sv
// Output bundle of the altpll_pll clock core. clkena is sampled on every
// inclk0 rising edge. c0..c3 and locked are registered levels.
interface altpll_pll_if;
   logic [3:0] clkena;
   logic       c0;
   logic       c1;
   logic       c2;
   logic       c3;
   logic       locked;

   modport master (output clkena, input c0, c1, c2, c3, locked);
   modport slave  (input clkena, output c0, c1, c2, c3, locked);
endinterface

// File: rtl/altpll_pll.sv
// Digital clock core: lock-delay counter followed by four divided,
// phase-offset, individually enabled registered clock outputs.
module altpll_pll #(
   parameter int LOCK_CYCLES = 64,
   parameter int C0_DIV      = 2,
   parameter int C0_HIGH     = 1,
   parameter int C0_PHASE    = 0,
   parameter int C1_DIV      = 4,
   parameter int C1_HIGH     = 2,
   parameter int C1_PHASE    = 0,
   parameter int C2_DIV      = 4,
   parameter int C2_HIGH     = 2,
   parameter int C2_PHASE    = 2,
   parameter int C3_DIV      = 8,
   parameter int C3_HIGH     = 4,
   parameter int C3_PHASE    = 0
) (
   input  logic        inclk0,
   input  logic        areset_n,
   altpll_pll_if.slave pll,
   output logic        dbg_state
);

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_LOCKED  = 1'b1
   } state_t;

   localparam int DIV [4] = '{C0_DIV, C1_DIV, C2_DIV, C3_DIV};
   localparam int HI  [4] = '{C0_HIGH, C1_HIGH, C2_HIGH, C3_HIGH};
   localparam int PH  [4] = '{C0_PHASE, C1_PHASE, C2_PHASE, C3_PHASE};

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

   if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("altpll_pll: LOCK_CYCLES out of range");
   end

   state_t      state_q, state_d;
   logic [15:0] lock_cnt_q, lock_cnt_d;
   logic        lock_edge;

   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= ST_ACQUIRE;
         lock_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // The counter freezes at LOCK_LAST once locked; only reset restarts it.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      lock_edge  = 1'b0;
      case (state_q)
         ST_ACQUIRE: begin
            if (lock_cnt_q == LOCK_LAST) begin
               state_d   = ST_LOCKED;
               lock_edge = 1'b1;
            end else begin
               lock_cnt_d = lock_cnt_q + 16'd1;
            end
         end
         ST_LOCKED: begin
            state_d = ST_LOCKED;
         end
         default: begin
            state_d = ST_ACQUIRE;
         end
      endcase
   end

   assign pll.locked = (state_q == ST_LOCKED);
   assign dbg_state  = state_q;

   for (genvar k = 0; k < 4; k++) begin : g_ch
      localparam logic [7:0] LAST  = 8'(DIV[k] - 1);
      localparam logic [8:0] HIGH  = 9'(HI[k]);
      localparam logic [7:0] PHASE = 8'(PH[k]);

      if (DIV[k] < 2 || DIV[k] > 256) begin : g_bad_div
         $error("altpll_pll: divider out of range");
      end
      if (HI[k] < 1 || HI[k] > DIV[k] - 1) begin : g_bad_high
         $error("altpll_pll: high time out of range");
      end
      if (PH[k] < 0 || PH[k] > DIV[k] - 1) begin : g_bad_phase
         $error("altpll_pll: phase out of range");
      end

      logic [7:0] cnt_q;
      logic       ck_q;

      // Counter runs regardless of clkena so re-enabling keeps the phase.
      always_ff @(posedge inclk0 or negedge areset_n) begin
         if (!areset_n) begin
            cnt_q <= 8'd0;
            ck_q  <= 1'b0;
         end else if (lock_edge) begin
            cnt_q <= PHASE;
            ck_q  <= 1'b0;
         end else if (state_q == ST_LOCKED) begin
            ck_q  <= pll.clkena[k] & ({1'b0, cnt_q} < HIGH);
            cnt_q <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
         end
      end
   end

   assign pll.c0 = g_ch[0].ck_q;
   assign pll.c1 = g_ch[1].ck_q;
   assign pll.c2 = g_ch[2].ck_q;
   assign pll.c3 = g_ch[3].ck_q;

endmodule

// File: tb/tb_altpll_pll.sv
// Bench for altpll_pll: three instances (default, short lock with odd c3,
// single-cycle lock) checked edge by edge against a closed-form waveform model.
module tb_altpll_pll;

   logic       inclk0 = 1'b0;
   logic       areset_n;
   logic [3:0] clkena;
   logic       dbg_a, dbg_b, dbg_c;

   always #5 inclk0 = ~inclk0;

   altpll_pll_if if_a ();
   altpll_pll_if if_b ();
   altpll_pll_if if_c ();

   assign if_a.clkena = clkena;
   assign if_b.clkena = clkena;
   assign if_c.clkena = clkena;

   altpll_pll dut_a (
      .inclk0    (inclk0),
      .areset_n  (areset_n),
      .pll       (if_a),
      .dbg_state (dbg_a)
   );

   altpll_pll #(
      .LOCK_CYCLES (4),
      .C3_DIV      (5),
      .C3_HIGH     (2),
      .C3_PHASE    (3)
   ) dut_b (
      .inclk0    (inclk0),
      .areset_n  (areset_n),
      .pll       (if_b),
      .dbg_state (dbg_b)
   );

   altpll_pll #(
      .LOCK_CYCLES (1)
   ) dut_c (
      .inclk0    (inclk0),
      .areset_n  (areset_n),
      .pll       (if_c),
      .dbg_state (dbg_c)
   );

   localparam int A_L = 64;
   localparam int B_L = 4;
   localparam int C_L = 1;
   localparam int A_DIV [4] = '{2, 4, 4, 8};
   localparam int A_HI  [4] = '{1, 2, 2, 4};
   localparam int A_PH  [4] = '{0, 0, 2, 0};
   localparam int B_DIV [4] = '{2, 4, 4, 5};
   localparam int B_HI  [4] = '{1, 2, 2, 2};
   localparam int B_PH  [4] = '{0, 0, 2, 3};

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          n            = 0;
   logic [14:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Expected {locked,c3,c2,c1,c0} on edge nn after release (nn=0: in reset).
   function automatic logic [4:0] model(input int nn, input int lk, input int dv[4],
                                        input int hi[4], input int ph[4], input logic [3:0] en);
      logic [4:0] r;
      int p;
      r = 5'd0;
      if (nn >= lk) begin
         r[4] = 1'b1;
         if (nn > lk) begin
            for (int k = 0; k < 4; k++) begin
               p = (ph[k] + nn - lk - 1) % dv[k];
               r[k] = en[k] && (p < hi[k]);
            end
         end
      end
      return r;
   endfunction

   function automatic logic [14:0] actual();
      return {if_c.locked, if_c.c3, if_c.c2, if_c.c1, if_c.c0,
              if_b.locked, if_b.c3, if_b.c2, if_b.c1, if_b.c0,
              if_a.locked, if_a.c3, if_a.c2, if_a.c1, if_a.c0};
   endfunction

   task automatic compare_all(input string tag);
      logic [14:0] got, e;
      got = actual();
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "_a"}, {27'd0, got[4:0]},   {27'd0, e[4:0]});
         check_eq({tag, "_b"}, {27'd0, got[9:5]},   {27'd0, e[9:5]});
         check_eq({tag, "_c"}, {27'd0, got[14:10]}, {27'd0, e[14:10]});
      end
   endtask

   // Drive clkena away from the edge, predict the next edge, then check it.
   task automatic drive_edge(input logic [3:0] en);
      int nn;
      clkena = en;
      nn = areset_n ? n + 1 : 0;
      exp_q.push_back({model(nn, C_L, A_DIV, A_HI, A_PH, en),
                       model(nn, B_L, B_DIV, B_HI, B_PH, en),
                       model(nn, A_L, A_DIV, A_HI, A_PH, en)});
      @(posedge inclk0);
      n = nn;
      #1;
      compare_all($sformatf("edge%0d", nn));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset_n = 1'b0;
      clkena   = 4'hF;
      #2;
      exp_q.push_back(15'd0);
      compare_all("reset_initial");
      for (int i = 0; i < 3; i++) drive_edge(4'hF);

      // Release, lock and free-running waveforms for all three instances.
      areset_n = 1'b1;
      n = 0;
      for (int i = 0; i < A_L + 32; i++) drive_edge(4'hF);

      // c1 disabled for six edges, then re-enabled.
      for (int i = 0; i < 6; i++) drive_edge(4'b1101);
      for (int i = 0; i < 12; i++) drive_edge(4'hF);

      for (int i = 0; i < 20; i++) drive_edge(4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) drive_edge(4'hF);

      // Asynchronous reset between edges while locked.
      #3;
      areset_n = 1'b0;
      #1;
      exp_q.push_back(15'd0);
      compare_all("reset_async");
      check_eq("dbg_state_reset", {29'd0, dbg_a, dbg_b, dbg_c}, 32'd0);
      for (int i = 0; i < 2; i++) drive_edge(4'hF);

      areset_n = 1'b1;
      n = 0;
      for (int i = 0; i < A_L + 8; i++) drive_edge(4'hF);
      check_eq("dbg_state_locked", {29'd0, dbg_a, dbg_b, dbg_c}, 32'd7);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
